// File: rtl/seq_mul_div.sv
// seq_mul_div: multi-cycle signed Booth multiplier and restoring divider,
// retiring one bit per cycle and returning a 2*WIDTH result as hi/lo halves.
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic             op_q, dz_q, neg_q_q, neg_r_q, qm1_q, qm1_d;
    logic             busy_q, done_q, div_by_zero_q;
    logic [WIDTH:0]   acc_q, acc_d, m_q, sum, shifted, diff;
    logic [WIDTH-1:0] q_q, q_d, a_mag, b_mag, quo, rem, hi_q, lo_q;
    logic             b_zero;

    // acc/m are WIDTH+1 bits so -2^31 survives both Booth subtract and magnitude compare
    always_comb begin
        a_mag   = operand_a[WIDTH-1] ? -operand_a : operand_a;
        b_mag   = operand_b[WIDTH-1] ? -operand_b : operand_b;
        b_zero  = operand_b == '0;
        sum     = acc_q + (({q_q[0], qm1_q} == 2'b01) ? m_q :
                           ({q_q[0], qm1_q} == 2'b10) ? -m_q : '0);
        shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff    = shifted - m_q;
        acc_d   = op_q ? (diff[WIDTH] ? shifted : diff) : {sum[WIDTH], sum[WIDTH:1]};
        q_d     = op_q ? {q_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        quo     = neg_q_q ? -q_q : q_q;
        rem     = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            op_q          <= 1'b0;
            dz_q          <= 1'b0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            qm1_q         <= 1'b0;
            acc_q         <= '0;
            m_q           <= '0;
            q_q           <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= op;
                    busy_q  <= 1'b1;
                    count_q <= '0;
                    qm1_q   <= 1'b0;
                    acc_q   <= '0;
                    dz_q    <= op && b_zero;
                    q_q     <= !op ? operand_b : (b_zero ? operand_a : a_mag);
                    m_q     <= op ? {1'b0, b_mag} : {operand_a[WIDTH-1], operand_a};
                    neg_q_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_r_q <= operand_a[WIDTH-1];
                    state_q <= (op && b_zero) ? FIX : RUN;
                end
                RUN: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    qm1_q   <= qm1_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    div_by_zero_q <= dz_q;
                    hi_q          <= dz_q ? q_q : op_q ? rem : acc_q[WIDTH-1:0];
                    lo_q          <= dz_q ? '1 : op_q ? quo : q_q;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign result_hi   = hi_q;
    assign result_lo   = lo_q;
endmodule
